// File: rtl/instruction_fetch.sv
// Instruction fetch stage: issues reads from pc, buffers returned
// words with their fetch address in a 2-deep queue toward decode.
module instruction_fetch #(
    parameter int INSTR_W = 16,
    parameter int ADDR_W  = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    input  logic               flush,
    input  logic [ADDR_W-1:0]  pc,
    output logic               enable_increment,
    output logic               imem_en,
    output logic [ADDR_W-1:0]  imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc,
    output logic               instr_valid,
    input  logic               instr_ready
);

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [ADDR_W-1:0]  pc;
    } entry_t;

    logic [1:0]        count;
    logic              inflight;
    logic [ADDR_W-1:0] tag;
    entry_t            head_q;
    entry_t            tail_q;

    logic       pop;
    logic       push;
    logic       issue;
    logic [1:0] in_use;
    entry_t     fill;

    assign in_use = count + {1'b0, inflight};
    assign pop    = instr_valid & instr_ready;
    assign push   = inflight & ~flush;
    // Gated by reset so the strobes read zero while reset is held.
    assign issue  = reset & run & ~flush & ((in_use < 2'd2) | pop);
    assign fill   = {imem_rdata, tag};

    assign instr_valid      = (count != 2'd0);
    assign instr            = head_q.instr;
    assign instr_pc         = head_q.pc;
    assign imem_en          = issue;
    assign enable_increment = issue;
    assign imem_addr        = issue ? pc : '0;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count    <= 2'd0;
            inflight <= 1'b0;
            tag      <= '0;
            head_q   <= '0;
            tail_q   <= '0;
        end else begin
            // Read data is valid exactly one cycle after the strobe.
            inflight <= issue;
            if (issue) begin
                tag <= pc;
            end
            if (flush) begin
                count <= 2'd0;
            end else begin
                case ({push, pop})
                    2'b10: begin
                        if (count == 2'd0) begin
                            head_q <= fill;
                        end else begin
                            tail_q <= fill;
                        end
                        count <= count + 2'd1;
                    end
                    2'b01: begin
                        head_q <= tail_q;
                        count  <= count - 2'd1;
                    end
                    2'b11: begin
                        if (count == 2'd1) begin
                            head_q <= fill;
                        end else begin
                            head_q <= tail_q;
                            tail_q <= fill;
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

endmodule
